prng_keystream_ctrl: RTL and testbench

Sequencer and buffer for the chaotic PRNG core in the image-encryption datapath. Latches three IEEE-754 seeds, pulses the PRNG's one-cycle `tvalid` to start it, discards a configurable warm-up run of outputs, then packs each PRNG result triple into a 24-bit keystream word. Words go through a small FIFO to the pixel XOR stage over a valid/ready handshake. It stops after exactly the requested number of words and reports done, overflow and accepted count.

---
 rtl/prng_keystream_ctrl.sv | 104 ++++++++++
 tb/tb_prng_keystream_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prng_keystream_ctrl.sv
// prng_keystream_ctrl: seeds the chaotic PRNG, skips its warm-up outputs and
// buffers packed 24-bit keystream words in a small FIFO for the XOR stage.
module prng_keystream_ctrl #(
  parameter int PRECISION  = 32,
  parameter int CNT_W      = 20,
  parameter int DISCARD    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PRECISION-1:0] seed0,
  input  logic [PRECISION-1:0] seed1,
  input  logic [PRECISION-1:0] seed2,
  input  logic [CNT_W-1:0]     num_words,
  output logic                 prng_tvalid,
  output logic [PRECISION-1:0] prng_x0,
  output logic [PRECISION-1:0] prng_x1,
  output logic [PRECISION-1:0] prng_x2,
  input  logic                 prng_valid,
  input  logic [PRECISION-1:0] prng_r1,
  input  logic [PRECISION-1:0] prng_r2,
  input  logic [PRECISION-1:0] prng_r3,
  output logic                 ks_valid,
  input  logic                 ks_ready,
  output logic [23:0]          ks_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_W-1:0]     accepted
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = DISCARD > 1 ? $clog2(DISCARD + 1) : 1;
  typedef enum logic [2:0] {IDLE, SEED, WARMUP, RUN, DRAIN, DONE} state_t;
  state_t           r_state, w_next;
  logic [23:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic [CNT_W-1:0] r_num;
  logic [DW-1:0]    r_disc;
  logic             w_start, w_full, w_pop, w_push, w_last_warm, w_unused;
  assign w_start     = r_state == IDLE && start;
  assign w_full      = r_cnt == (AW + 1)'(FIFO_DEPTH);
  assign ks_valid    = r_cnt != '0;
  assign ks_data     = ks_valid ? r_mem[r_rp] : '0;
  assign w_pop       = ks_valid && ks_ready;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign w_push      = r_state == RUN && prng_valid && (!w_full || w_pop);
  assign w_last_warm = prng_valid && int'(r_disc) == DISCARD - 1;
  assign prng_tvalid = r_state == SEED;
  assign busy        = r_state != IDLE;
  assign done        = r_state == DONE;
  assign w_unused    = ^{prng_r1[PRECISION-1:8], prng_r2[PRECISION-1:8], prng_r3[PRECISION-1:8]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (num_words == '0 ? DONE : SEED) : IDLE;
      SEED:    w_next = DISCARD > 0 ? WARMUP : RUN;
      WARMUP:  w_next = w_last_warm ? RUN : WARMUP;
      RUN:     w_next = w_push && accepted + 1'b1 == r_num ? DRAIN : RUN;
      DRAIN:   w_next = ks_valid ? DRAIN : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      prng_x0  <= '0;
      prng_x1  <= '0;
      prng_x2  <= '0;
      r_num    <= '0;
      r_disc   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      overflow <= 1'b0;
      accepted <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        prng_x0  <= seed0;
        prng_x1  <= seed1;
        prng_x2  <= seed2;
        r_num    <= num_words;
        r_disc   <= '0;
        r_wp     <= '0;
        r_rp     <= '0;
        r_cnt    <= '0;
        overflow <= 1'b0;
        accepted <= '0;
      end else begin
        if (r_state == WARMUP && prng_valid) r_disc <= r_disc + 1'b1;
        if (r_state == RUN && prng_valid && !w_push) overflow <= 1'b1;
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_push) accepted <= accepted + 1'b1;
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
      end
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {prng_r1[7:0], prng_r2[7:0], prng_r3[7:0]};
endmodule

// File: tb/tb_prng_keystream_ctrl.sv
// tb_prng_keystream_ctrl: vector table, directed corner sequences and random runs,
// all checked against a queue-based transaction model of the keystream controller.
module tb_prng_keystream_ctrl;
  localparam int P = 32, CW = 20, DISC = 2, FD = 4;
  logic clk = 0, reset_n = 0, start = 0, pv = 0, ks_ready = 0;
  logic [P-1:0] seed0 = 0, seed1 = 0, seed2 = 0, r1 = 0, r2 = 0, r3 = 0;
  logic [CW-1:0] num = 0;
  logic prng_tvalid, ks_valid, busy, done, overflow;
  logic [P-1:0] prng_x0, prng_x1, prng_x2;
  logic [23:0] ks_data;
  logic [CW-1:0] accepted;
  int n_cmp = 0, n_bad = 0;

  prng_keystream_ctrl #(.PRECISION(P), .CNT_W(CW), .DISCARD(DISC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .seed0(seed0), .seed1(seed1), .seed2(seed2),
    .num_words(num), .prng_tvalid(prng_tvalid), .prng_x0(prng_x0), .prng_x1(prng_x1),
    .prng_x2(prng_x2), .prng_valid(pv), .prng_r1(r1), .prng_r2(r2), .prng_r3(r3),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .busy(busy), .done(done),
    .overflow(overflow), .accepted(accepted));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 seed, 2 warm-up, 3 run, 4 drain, 5 done.
  int m_mode = 0, m_skip = 0, m_left = 0;
  logic [23:0] m_q[$];
  logic [CW-1:0] m_acc = 0;
  logic m_ovf = 0;
  logic [P-1:0] m_x[3] = '{0, 0, 0};

  function automatic logic [23:0] pack_w();
    return {r1[7:0], r2[7:0], r3[7:0]};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_q.delete(); m_acc = 0; m_ovf = 0; m_x = '{0, 0, 0};
  endtask

  task automatic model_step();
    bit pop = m_q.size() > 0 && ks_ready;
    bit full = m_q.size() == FD;
    bit was_empty = m_q.size() == 0;
    if (m_mode == 0 && start) begin
      m_x = '{seed0, seed1, seed2}; m_acc = 0; m_ovf = 0; m_q.delete();
      m_left = int'(num); m_skip = DISC; m_mode = num == 0 ? 5 : 1;
      return;
    end
    if (pop) void'(m_q.pop_front());
    case (m_mode)
      1: m_mode = DISC > 0 ? 2 : 3;
      2: if (pv) begin m_skip--; if (m_skip == 0) m_mode = 3; end
      3: if (pv) begin
           if (!full || pop) begin
             m_q.push_back(pack_w()); m_acc++; m_left--;
             if (m_left == 0) m_mode = 4;
           end else m_ovf = 1;
         end
      4: if (was_empty) m_mode = 5;
      5: m_mode = 0;
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("prng_tvalid", prng_tvalid, m_mode == 1);
    chk("busy", busy, m_mode != 0);
    chk("done", done, m_mode == 5);
    chk("ks_valid", ks_valid, m_q.size() > 0);
    chk("ks_data", ks_data, m_q.size() > 0 ? m_q[0] : 24'h0);
    chk("overflow", overflow, m_ovf);
    chk("accepted", accepted, m_acc);
    chk("prng_x0", prng_x0, m_x[0]);
    chk("prng_x1", prng_x1, m_x[1]);
    chk("prng_x2", prng_x2, m_x[2]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_word(input logic [23:0] w);
    r1 = ($urandom() & 32'hFFFF_FF00) | {24'h0, w[23:16]};
    r2 = ($urandom() & 32'hFFFF_FF00) | {24'h0, w[15:8]};
    r3 = ($urandom() & 32'hFFFF_FF00) | {24'h0, w[7:0]};
  endtask

  task automatic rand_seeds();
    seed0 = $urandom(); seed1 = $urandom(); seed2 = $urandom();
  endtask

  task automatic finish_run(input bit rnd, output bit saw_done);
    saw_done = 0;
    for (int c = 0; c < 400 && m_mode != 0; c++) begin
      pv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ks_ready = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
      start = rnd ? $urandom_range(0, 15) == 0 : 1'b0;
      num = CW'($urandom_range(0, 10));
      if (start) rand_seeds();
      set_word(24'($urandom()));
      tick();
      if (done) saw_done = 1;
    end
    start = 0;
    chk("run_end_busy", busy, 0);
  endtask

  typedef struct {
    logic st;
    logic [CW-1:0] nw;
    logic pv;
    logic [23:0] w;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t v(logic st, logic [CW-1:0] nw, logic p, logic [23:0] w, logic tv,
                             logic kv, logic [23:0] kd, logic dn, logic by, logic [3:0] acc);
    return '{st, nw, p, w, {tv, kv, kd, dn, by, acc}};
  endfunction

  initial begin
    vec_t tab[24];
    bit saw;
    logic [P-1:0] s0;
    tab[0]  = v(1, 3, 0, 0,         1, 0, 0,         0, 1, 0);
    tab[1]  = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 0);
    tab[2]  = v(0, 0, 1, 24'hA1A2A3, 0, 0, 0,        0, 1, 0);
    tab[3]  = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 0);
    tab[4]  = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 0);
    tab[5]  = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 0);
    tab[6]  = v(0, 0, 1, 24'hB1B2B3, 0, 0, 0,        0, 1, 0);
    tab[7]  = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 0);
    tab[8]  = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 0);
    tab[9]  = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 0);
    tab[10] = v(0, 0, 1, 24'hC1C2C3, 0, 1, 24'hC1C2C3, 0, 1, 1);
    tab[11] = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 1);
    tab[12] = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 1);
    tab[13] = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 1);
    tab[14] = v(0, 0, 1, 24'hD1D2D3, 0, 1, 24'hD1D2D3, 0, 1, 2);
    tab[15] = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 2);
    tab[16] = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 2);
    tab[17] = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 2);
    tab[18] = v(0, 0, 1, 24'hE1E2E3, 0, 1, 24'hE1E2E3, 0, 1, 3);
    tab[19] = v(0, 0, 0, 0,         0, 0, 0,         0, 1, 3);
    tab[20] = v(0, 0, 0, 0,         0, 0, 0,         1, 1, 3);
    tab[21] = v(0, 0, 0, 0,         0, 0, 0,         0, 0, 3);
    tab[22] = v(1, 0, 0, 0,         0, 0, 0,         1, 1, 0);
    tab[23] = v(0, 0, 0, 0,         0, 0, 0,         0, 0, 0);
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1;
    // Basic run then a zero-length run, one table row per clock.
    for (int i = 0; i < 24; i++) begin
      start = tab[i].st; num = tab[i].nw; pv = tab[i].pv; ks_ready = 1;
      set_word(tab[i].w);
      rand_seeds();
      tick();
      chk($sformatf("vec%0d", i), {prng_tvalid, ks_valid, ks_data, done, busy, accepted[3:0]}, tab[i].exp);
    end
    start = 0;
    // Backpressure: fill, overflow, then drain in order to completion.
    rand_seeds(); num = 6; start = 1; ks_ready = 0; pv = 0; tick();
    start = 0; tick();
    for (int i = 0; i < 9; i++) begin pv = 1; set_word(24'($urandom())); tick(); end
    chk("bp_overflow", overflow, 1);
    chk("bp_accepted", accepted, 4);
    finish_run(0, saw);
    chk("bp_done_seen", saw, 1);
    chk("bp_final_accepted", accepted, 6);
    // Full FIFO with a simultaneous pop and push, then an ignored start.
    rand_seeds(); s0 = seed0; num = 6; start = 1; ks_ready = 0; pv = 0; tick();
    start = 0; tick();
    for (int i = 0; i < 6; i++) begin pv = 1; set_word(24'($urandom())); tick(); end
    chk("full_ks_valid", ks_valid, 1);
    ks_ready = 1; pv = 1; set_word(24'h5A5A5A); tick();
    chk("full_pop_push_ovf", overflow, 0);
    chk("full_pop_push_acc", accepted, 5);
    ks_ready = 0; pv = 0; start = 1; seed0 = ~s0; num = 2; tick();
    start = 0;
    chk("busy_start_x0", prng_x0, s0);
    chk("busy_start_acc", accepted, 5);
    finish_run(0, saw);
    chk("ign_done_seen", saw, 1);
    // Asynchronous reset with two words queued.
    rand_seeds(); num = 5; start = 1; ks_ready = 0; pv = 0; tick();
    start = 0; tick();
    for (int i = 0; i < 4; i++) begin pv = 1; set_word(24'($urandom())); tick(); end
    chk("pre_reset_ks_valid", ks_valid, 1);
    pv = 0;
    #2 reset_n = 0;
    #1;
    chk("rst_outputs", {prng_tvalid, ks_valid, ks_data, busy, done, overflow, accepted, prng_x0}, 0);
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1;
    // Randomized runs, including stray starts and zero lengths.
    for (int r = 0; r < 10; r++) begin
      rand_seeds(); num = CW'($urandom_range(0, 10)); start = 1; pv = 0; tick();
      start = 0;
      finish_run(1, saw);
      for (int k = 0; k < 3; k++) begin ks_ready = 1'($urandom_range(0, 1)); tick(); end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
